axil_multiplier: RTL and testbench

AXI4-Lite slave holding two 32-bit operand registers and a 64-bit unsigned product, readable as two 32-bit words. The host (AXI interconnect port "s2") writes operands A and B, then reads the product. It is a memory-mapped accelerator peripheral; all access is by single-beat AXI-Lite transactions.

---
 rtl/axil_multiplier.sv | 142 ++++++++++++++
 tb/tb_axil_multiplier.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_multiplier.sv
// AXI4-Lite slave with two operand registers and a registered 64-bit unsigned product.
// Offsets 0x10/0x14 hold the operands; 0x18/0x1C return the low and high product words.
module axil_multiplier #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    s2_axi_aclk,
  input  logic                    s2_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s2_axi_awaddr,
  input  logic                    s2_axi_awvalid,
  output logic                    s2_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s2_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s2_axi_wstrb,
  input  logic                    s2_axi_wvalid,
  output logic                    s2_axi_wready,
  output logic [1:0]              s2_axi_bresp,
  output logic                    s2_axi_bvalid,
  input  logic                    s2_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s2_axi_araddr,
  input  logic                    s2_axi_arvalid,
  output logic                    s2_axi_arready,
  output logic [DATA_WIDTH-1:0]   s2_axi_rdata,
  output logic [1:0]              s2_axi_rresp,
  output logic                    s2_axi_rvalid,
  input  logic                    s2_axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                    r_awHeld;
  logic [2:0]              r_awIdx;
  logic                    r_wHeld;
  logic [DATA_WIDTH-1:0]   r_wData;
  logic [STRB_WIDTH-1:0]   r_wStrb;
  logic                    r_bvalid;
  logic [DATA_WIDTH-1:0]   r_opA;
  logic [DATA_WIDTH-1:0]   r_opB;
  logic [2*DATA_WIDTH-1:0] r_prod;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_rvalid;

  logic                    w_awHs;
  logic                    w_wHs;
  logic                    w_arHs;
  logic                    w_commit;
  logic [DATA_WIDTH-1:0]   w_target;
  logic [DATA_WIDTH-1:0]   w_merged;
  logic [DATA_WIDTH-1:0]   w_readData;
  logic                    w_unused;

  // Address bits outside [4:2] take no part in decode.
  assign w_unused = ^{s2_axi_awaddr[ADDR_WIDTH-1:5], s2_axi_awaddr[1:0],
                      s2_axi_araddr[ADDR_WIDTH-1:5], s2_axi_araddr[1:0]};

  assign s2_axi_awready = !r_awHeld && !r_bvalid && !s2_axi_areset;
  assign s2_axi_wready  = !r_wHeld && !r_bvalid && !s2_axi_areset;
  assign s2_axi_arready = !r_rvalid && !s2_axi_areset;
  assign s2_axi_bvalid  = r_bvalid;
  assign s2_axi_bresp   = 2'b00;
  assign s2_axi_rvalid  = r_rvalid;
  assign s2_axi_rdata   = r_rdata;
  assign s2_axi_rresp   = 2'b00;

  assign w_awHs   = s2_axi_awvalid && s2_axi_awready;
  assign w_wHs    = s2_axi_wvalid && s2_axi_wready;
  assign w_arHs   = s2_axi_arvalid && s2_axi_arready;
  assign w_commit = r_awHeld && r_wHeld;

  always_comb begin
    w_target = (r_awIdx == 3'd4) ? r_opA : r_opB;
    w_merged = w_target;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (r_wStrb[i]) w_merged[8*i +: 8] = r_wData[8*i +: 8];
    end
  end

  always_comb begin
    w_readData = '0;
    case (s2_axi_araddr[4:2])
      3'd4:    w_readData = r_opA;
      3'd5:    w_readData = r_opB;
      3'd6:    w_readData = r_prod[DATA_WIDTH-1:0];
      3'd7:    w_readData = r_prod[2*DATA_WIDTH-1:DATA_WIDTH];
      default: w_readData = '0;
    endcase
  end

  // AW and W latch independently; the commit fires once both are held.
  always_ff @(posedge s2_axi_aclk) begin
    if (s2_axi_areset) begin
      r_awHeld <= 1'b0;
      r_awIdx  <= '0;
      r_wHeld  <= 1'b0;
      r_wData  <= '0;
      r_wStrb  <= '0;
      r_bvalid <= 1'b0;
      r_opA    <= '0;
      r_opB    <= '0;
    end else begin
      if (w_awHs) begin
        r_awHeld <= 1'b1;
        r_awIdx  <= s2_axi_awaddr[4:2];
      end
      if (w_wHs) begin
        r_wHeld <= 1'b1;
        r_wData <= s2_axi_wdata;
        r_wStrb <= s2_axi_wstrb;
      end
      if (w_commit) begin
        r_awHeld <= 1'b0;
        r_wHeld  <= 1'b0;
        r_bvalid <= 1'b1;
        if (r_awIdx == 3'd4) r_opA <= w_merged;
        else if (r_awIdx == 3'd5) r_opB <= w_merged;
      end else if (r_bvalid && s2_axi_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge s2_axi_aclk) begin
    if (s2_axi_areset) begin
      r_prod <= '0;
    end else begin
      r_prod <= {{DATA_WIDTH{1'b0}}, r_opA} * {{DATA_WIDTH{1'b0}}, r_opB};
    end
  end

  // Read data is captured at the AR handshake, so it reflects pre-commit state.
  always_ff @(posedge s2_axi_aclk) begin
    if (s2_axi_areset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else if (w_arHs) begin
      r_rdata  <= w_readData;
      r_rvalid <= 1'b1;
    end else if (r_rvalid && s2_axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_multiplier.sv
// Self-checking bench for axil_multiplier: vector table, hand-written corner sequences,
// and randomized writes/reads checked against a register-level reference model.
module tb_axil_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int vectorCount = 0;
  int missCount   = 0;

  logic [31:0] modelA;
  logic [31:0] modelB;

  typedef struct {
    logic [7:0]  wAddr;
    logic [31:0] wData;
    logic [3:0]  wStrb;
    logic [7:0]  rAddr;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[12];

  axil_multiplier #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .s2_axi_aclk   (clk),
    .s2_axi_areset (reset),
    .s2_axi_awaddr (awaddr),
    .s2_axi_awvalid(awvalid),
    .s2_axi_awready(awready),
    .s2_axi_wdata  (wdata),
    .s2_axi_wstrb  (wstrb),
    .s2_axi_wvalid (wvalid),
    .s2_axi_wready (wready),
    .s2_axi_bresp  (bresp),
    .s2_axi_bvalid (bvalid),
    .s2_axi_bready (bready),
    .s2_axi_araddr (araddr),
    .s2_axi_arvalid(arvalid),
    .s2_axi_arready(arready),
    .s2_axi_rdata  (rdata),
    .s2_axi_rresp  (rresp),
    .s2_axi_rvalid (rvalid),
    .s2_axi_rready (rready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: operand registers plus the product computed on demand.
  function automatic logic [31:0] modelRead(input logic [7:0] addr);
    logic [63:0] prod;
    prod = 64'(modelA) * 64'(modelB);
    case (addr[4:2])
      3'd4:    return modelA;
      3'd5:    return modelB;
      3'd6:    return prod[31:0];
      3'd7:    return prod[63:32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic modelWrite(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    for (int i = 0; i < 4; i++) begin
      if (strb[i] && addr[4:2] == 3'd4) modelA[8*i +: 8] = data[8*i +: 8];
      if (strb[i] && addr[4:2] == 3'd5) modelB[8*i +: 8] = data[8*i +: 8];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Present AW and W together and hand both to the DUT, without waiting for B.
  task automatic startWrite(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int  n;
    bit  awDone;
    bit  wDone;
    awaddr  = addr;
    wdata   = data;
    wstrb   = strb;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      awDone = awvalid && awready;
      wDone  = wvalid && wready;
      tick();
      if (awDone) awvalid = 1'b0;
      if (wDone)  wvalid  = 1'b0;
      n++;
    end
    if (awvalid || wvalid) begin
      checkOutput("write handshake timeout", {awvalid, wvalid}, 0);
      awvalid = 1'b0;
      wvalid  = 1'b0;
    end
  endtask

  task automatic waitB();
    int n;
    n = 0;
    while (!bvalid && n < 20) begin
      tick();
      n++;
    end
    checkOutput("bvalid", bvalid, 1);
    checkOutput("bresp", bresp, 0);
  endtask

  // Full write: handshake, response, and model update.
  task automatic applyStimulus(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    startWrite(addr, data, strb);
    waitB();
    tick();
    checkOutput("bvalid drop", bvalid, 0);
    modelWrite(addr, data, strb);
  endtask

  task automatic readReg(input logic [7:0] addr, output logic [31:0] data);
    int n;
    araddr  = addr;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      tick();
      n++;
    end
    if (!arready) begin
      checkOutput("arready timeout", arready, 1);
      arvalid = 1'b0;
      data = 'x;
      return;
    end
    tick();
    arvalid = 1'b0;
    checkOutput("rvalid latency", rvalid, 1);
    checkOutput("rresp", rresp, 0);
    data = rdata;
    if (rready) tick();
  endtask

  task automatic checkRead(input string name, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] got;
    readReg(addr, got);
    checkOutput(name, got, exp);
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    checkOutput("reset awready", awready, 0);
    checkOutput("reset wready", wready, 0);
    checkOutput("reset bvalid", bvalid, 0);
    checkOutput("reset arready", arready, 0);
    checkOutput("reset rvalid", rvalid, 0);
    checkOutput("reset rdata", rdata, 0);
    reset = 1'b0;
    modelA = '0;
    modelB = '0;
    tick();
  endtask

  initial begin
    int          pulses;
    int          n;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] held;

    reset = 1'b1; awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 1'b1; araddr = '0; arvalid = 0; rready = 1'b1;
    modelA = '0; modelB = '0;

    vecs[0]  = '{8'h10, 32'h00000278, 4'hF, 8'h10, 32'h00000278};
    vecs[1]  = '{8'h14, 32'h00001468, 4'hF, 8'h14, 32'h00001468};
    vecs[2]  = '{8'h00, 32'hDEADBEEF, 4'hF, 8'h18, 32'h003260C0};
    vecs[3]  = '{8'h18, 32'h00001234, 4'hF, 8'h1C, 32'h00000000};
    vecs[4]  = '{8'h10, 32'hFFFFFFFF, 4'hF, 8'h10, 32'hFFFFFFFF};
    vecs[5]  = '{8'h14, 32'hFFFFFFFF, 4'hF, 8'h18, 32'h00000001};
    vecs[6]  = '{8'h08, 32'h00000055, 4'hF, 8'h1C, 32'hFFFFFFFE};
    vecs[7]  = '{8'h10, 32'h11223344, 4'hF, 8'h10, 32'h11223344};
    vecs[8]  = '{8'h10, 32'hAABBCCDD, 4'h3, 8'h10, 32'h1122CCDD};
    vecs[9]  = '{8'h1C, 32'h77777777, 4'hF, 8'h04, 32'h00000000};
    vecs[10] = '{8'h94, 32'h00000002, 4'hF, 8'h18, 32'h224599BA};
    vecs[11] = '{8'h14, 32'h00010000, 4'h4, 8'h14, 32'h00010002};

    $display("[TB] reset checks");
    doReset();
    checkRead("reset OP_A", 8'h10, 32'h0);
    checkRead("reset OP_B", 8'h14, 32'h0);
    checkRead("reset PROD_LO", 8'h18, 32'h0);
    checkRead("reset PROD_HI", 8'h1C, 32'h0);

    $display("[TB] vector table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].wAddr, vecs[i].wData, vecs[i].wStrb);
      checkRead($sformatf("vector %0d", i), vecs[i].rAddr, vecs[i].expData);
    end

    $display("[TB] W presented two cycles before AW");
    applyStimulus(8'h10, 32'h11223344, 4'hF);
    wdata = 32'hAABBCCDD; wstrb = 4'h3; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    checkOutput("wready after W latch", wready, 0);
    tick();
    checkOutput("no bvalid without AW", bvalid, 0);
    awaddr = 8'h10; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    pulses = 0;
    repeat (6) begin
      tick();
      if (bvalid) pulses++;
    end
    checkOutput("single bvalid pulse", pulses, 1);
    modelWrite(8'h10, 32'hAABBCCDD, 4'h3);
    checkRead("split write OP_A", 8'h10, 32'h1122CCDD);

    $display("[TB] back-to-back writes");
    awaddr = 8'h14; wdata = 32'h00000005; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    pulses = 0;
    repeat (9) begin
      tick();
      if (bvalid) pulses++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    checkOutput("back-to-back bvalid count", pulses, 3);
    modelWrite(8'h14, 32'h00000005, 4'hF);
    checkRead("back-to-back OP_B", 8'h14, modelRead(8'h14));

    $display("[TB] write response backpressure");
    bready = 1'b0;
    startWrite(8'h10, 32'hCAFEF00D, 4'hF);
    waitB();
    awaddr = 8'h14; awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("bvalid held %0d", i), bvalid, 1);
      checkOutput($sformatf("awready blocked %0d", i), awready, 0);
    end
    awvalid = 1'b0;
    bready = 1'b1;
    tick();
    checkOutput("bvalid released", bvalid, 0);
    modelWrite(8'h10, 32'hCAFEF00D, 4'hF);
    checkRead("backpressure OP_A", 8'h10, 32'hCAFEF00D);

    $display("[TB] read data backpressure");
    rready = 1'b0;
    readReg(8'h18, held);
    checkOutput("held read value", held, modelRead(8'h18));
    araddr = 8'h14; arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("rvalid held %0d", i), rvalid, 1);
      checkOutput($sformatf("rdata stable %0d", i), rdata, held);
      checkOutput($sformatf("arready blocked %0d", i), arready, 0);
    end
    arvalid = 1'b0;
    rready = 1'b1;
    tick();
    checkOutput("rvalid released", rvalid, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 40; i++) begin
      addr = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'b00};
      if (i % 3 != 0) addr[4:2] = 3'($urandom_range(4, 5));
      data = $urandom;
      applyStimulus(addr, data, 4'($urandom_range(0, 15)));
      addr = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'b00};
      checkRead($sformatf("random read %0d", i), addr, modelRead(addr));
    end

    $display("[TB] reset with a pending response");
    bready = 1'b0;
    startWrite(8'h10, 32'h12345678, 4'hF);
    waitB();
    doReset();
    bready = 1'b1;
    n = 0;
    repeat (3) begin
      tick();
      if (bvalid) n++;
    end
    checkOutput("dropped response", n, 0);
    checkRead("post-reset OP_A", 8'h10, 32'h0);
    checkRead("post-reset PROD_HI", 8'h1C, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
